// File: rtl/fetch_seq_pkg.sv
// Shared types and default sizing for the fetch/run sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int SEQ_D         = 12;
  localparam int SEQ_HALT_ADDR = 128;
  localparam int SEQ_CW        = 16;

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Candidate next program counter: absolute jump beats relative jump beats increment.
module pc_next
  import fetch_seq_pkg::*;
#(
  parameter int D = SEQ_D
) (
  input  logic [D-1:0] pc,
  input  logic         reljump_en,
  input  logic         absjump_en,
  input  logic [D-1:0] target,
  output logic [D-1:0] pc_nxt
);

  // Offsets are two's complement, so a plain D-bit add wraps correctly.
  always_comb begin
    if (absjump_en)
      pc_nxt = target;
    else if (reljump_en)
      pc_nxt = pc + target;
    else
      pc_nxt = pc + D'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/run controller: owns the PC, jumps, stalls and the req/done handshake.
// Optional saturating run-cycle counter enabled by FETCH_SEQ_CYCLE_CNT_EN.
//
// state | meaning
// IDLE  | waiting for req
// RUN   | fetching; PC advances unless stalled
// DONE  | run finished; waiting for req to drop
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int D          = SEQ_D,
  parameter int START_ADDR = 0,
  parameter int HALT_ADDR  = SEQ_HALT_ADDR,
  parameter int CW         = SEQ_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          reljump_en,
  input  logic          absjump_en,
  input  logic [D-1:0]  target,
  input  logic          halt,
  input  logic          stall,
  output logic [D-1:0]  prog_ctr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [D-1:0] HALT_PC  = D'(HALT_ADDR);

  seq_state_t   state;
  logic [D-1:0] pc_nxt;

  pc_next #(.D(D)) u_pc_next (
    .pc         (prog_ctr),
    .reljump_en (reljump_en),
    .absjump_en (absjump_en),
    .target     (target),
    .pc_nxt     (pc_nxt)
  );

  // Reaching HALT_PC wins over stall; a stall masks halt and jumps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= RUN;
            busy     <= 1'b1;
            prog_ctr <= START_PC;
          end
        end
        RUN: begin
          if (prog_ctr == HALT_PC || (!stall && halt)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!stall) begin
            prog_ctr <= pc_nxt;
          end
        end
        DONE: begin
          if (!req) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt_q <= '0;
    else if (state == IDLE && req)
      cnt_q <= '0;
    else if (state == RUN && cnt_q != '1)
      cnt_q <= cnt_q + CW'(1);
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a 12-bit instance and a narrow 4-bit wrap/saturation instance.
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    int pc;
    int busy;
    int done;
    int cnt;
  } exp_t;

  logic        clk, reset;
  logic        req_a, rel_a, abs_a, halt_a, stall_a;
  logic [11:0] tgt_a, pc_a;
  logic        busy_a, done_a;
  logic [15:0] cnt_a;
  logic        req_b, rel_b, abs_b, halt_b, stall_b;
  logic [3:0]  tgt_b, pc_b;
  logic        busy_b, done_b;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model: 0=idle, 1=run, 2=done
  int m_st[2], m_pc[2], m_cnt[2];
  int md[2] = '{12, 4};
  int ms[2] = '{0, 14};
  int mh[2] = '{128, 15};
  int mc[2] = '{16, 4};

  fetch_sequencer #(.D(12), .START_ADDR(0), .HALT_ADDR(128), .CW(16)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .reljump_en(rel_a), .absjump_en(abs_a),
    .target(tgt_a), .halt(halt_a), .stall(stall_a), .prog_ctr(pc_a), .busy(busy_a),
    .done(done_a), .cycle_cnt(cnt_a)
  );

  fetch_sequencer #(.D(4), .START_ADDR(14), .HALT_ADDR(15), .CW(4)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .reljump_en(rel_b), .absjump_en(abs_b),
    .target(tgt_b), .halt(halt_b), .stall(stall_b), .prog_ctr(pc_b), .busy(busy_b),
    .done(done_b), .cycle_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i]  = 0;
      m_pc[i]  = 0;
      m_cnt[i] = 0;
    end
  endfunction

  function automatic void model_edge(input int i, input bit rq, input bit rl, input bit ab,
                                     input int tg, input bit ht, input bit st);
    int mask = (1 << md[i]) - 1;
    case (m_st[i])
      0: if (rq) begin
        m_st[i]  = 1;
        m_pc[i]  = ms[i];
        m_cnt[i] = 0;
      end
      1: begin
        if (m_cnt[i] < (1 << mc[i]) - 1) m_cnt[i]++;
        if (m_pc[i] == mh[i]) m_st[i] = 2;
        else if (!st) begin
          if (ht) m_st[i] = 2;
          else if (ab) m_pc[i] = tg & mask;
          else if (rl) m_pc[i] = (m_pc[i] + tg) & mask;
          else m_pc[i] = (m_pc[i] + 1) & mask;
        end
      end
      default: if (!rq) m_st[i] = 0;
    endcase
  endfunction

  function automatic exp_t model_out(input int i);
    exp_t e;
    e.pc   = m_pc[i];
    e.busy = (m_st[i] == 1) ? 1 : 0;
    e.done = (m_st[i] == 2) ? 1 : 0;
    e.cnt  = CNT_EN ? m_cnt[i] : 0;
    return e;
  endfunction

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    model_edge(0, req_a, rel_a, abs_a, int'(tgt_a), halt_a, stall_a);
    model_edge(1, req_b, rel_b, abs_b, int'(tgt_b), halt_b, stall_b);
    q_a.push_back(model_out(0));
    q_b.push_back(model_out(1));
    @(negedge clk);
  endtask

  task automatic run_to(input int p);
    for (int k = 0; k < 300 && m_pc[0] != p; k++) step();
    chk("reach_pc", int'(pc_a), p);
  endtask

  // Monitor: compare DUT outputs against queued expectations just after each edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("a_pc", int'(pc_a), e.pc);
      chk("a_busy", int'(busy_a), e.busy);
      chk("a_done", int'(done_a), e.done);
      chk("a_cnt", int'(cnt_a), e.cnt);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("b_pc", int'(pc_b), e.pc);
      chk("b_busy", int'(busy_b), e.busy);
      chk("b_done", int'(done_b), e.done);
      chk("b_cnt", int'(cnt_b), e.cnt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {req_a, rel_a, abs_a, halt_a, stall_a} = '0;
    {req_b, rel_b, abs_b, halt_b, stall_b} = '0;
    tgt_a = '0;
    tgt_b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc_a", int'(pc_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    chk("rst_pc_b", int'(pc_b), 0);
    chk("rst_cnt_b", int'(cnt_b), 0);
    reset = 1'b0;
    step();

    // straight run to HALT_ADDR
    req_a = 1'b1;
    for (int k = 0; k < 200 && m_st[0] != 2; k++) step();
    chk("run_pc", int'(pc_a), 128);
    chk("run_done", int'(done_a), 1);
    chk("run_cnt", int'(cnt_a), CNT_EN ? 129 : 0);

    // four-phase handshake
    repeat (5) step();
    chk("hs_hold_done", int'(done_a), 1);
    req_a = 1'b0;
    step();
    chk("hs_idle_done", int'(done_a), 0);
    req_a = 1'b1;
    step();
    chk("hs_restart_pc", int'(pc_a), 0);
    chk("hs_restart_busy", int'(busy_a), 1);
    chk("hs_restart_cnt", int'(cnt_a), 0);

    // jumps
    run_to(5);
    abs_a = 1'b1; tgt_a = 12'd40;
    step();
    abs_a = 1'b0;
    chk("abs_jump", int'(pc_a), 40);
    rel_a = 1'b1; tgt_a = 12'hFFD;
    step();
    rel_a = 1'b0;
    chk("rel_jump_back", int'(pc_a), 37);
    abs_a = 1'b1; tgt_a = 12'd18;
    step();
    abs_a = 1'b0;
    run_to(20);
    abs_a = 1'b1; rel_a = 1'b1; tgt_a = 12'd7;
    step();
    abs_a = 1'b0; rel_a = 1'b0;
    chk("abs_beats_rel", int'(pc_a), 7);

    // stall masks halt, then halt ends the run
    run_to(9);
    stall_a = 1'b1; halt_a = 1'b1;
    repeat (3) step();
    chk("stall_pc", int'(pc_a), 9);
    chk("stall_busy", int'(busy_a), 1);
    stall_a = 1'b0;
    step();
    halt_a = 1'b0;
    chk("halt_done", int'(done_a), 1);
    chk("halt_pc", int'(pc_a), 9);
    req_a = 1'b0;
    step();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req_a   = ($urandom_range(0, 9) != 0);
      stall_a = ($urandom_range(0, 4) == 0);
      halt_a  = ($urandom_range(0, 24) == 0);
      abs_a   = ($urandom_range(0, 7) == 0);
      rel_a   = ($urandom_range(0, 5) == 0);
      tgt_a   = abs_a ? 12'($urandom_range(0, 200)) : 12'($urandom_range(0, 4095));
      step();
    end

    // drain to IDLE, then reset in the middle of a run
    {rel_a, abs_a, stall_a} = '0;
    req_a = 1'b0; halt_a = 1'b1;
    for (int k = 0; k < 5 && m_st[0] != 0; k++) step();
    halt_a = 1'b0; req_a = 1'b1;
    step();
    run_to(50);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", int'(pc_a), 0);
    chk("mid_rst_busy", int'(busy_a), 0);
    chk("mid_rst_done", int'(done_a), 0);
    chk("mid_rst_cnt", int'(cnt_a), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0; req_a = 1'b0;
    step();

    // narrow instance: silent wrap, counter saturation, halt at 15
    req_b = 1'b1;
    step();
    chk("b_start_pc", int'(pc_b), 14);
    rel_b = 1'b1; tgt_b = 4'd3;
    step();
    rel_b = 1'b0;
    chk("b_wrap_pc", int'(pc_b), 1);
    chk("b_wrap_busy", int'(busy_b), 1);
    stall_b = 1'b1;
    repeat (20) step();
    stall_b = 1'b0;
    chk("b_cnt_sat", int'(cnt_b), CNT_EN ? 15 : 0);
    for (int k = 0; k < 40 && m_st[1] != 2; k++) step();
    chk("b_done", int'(done_b), 1);
    chk("b_halt_pc", int'(pc_b), 15);
    req_b = 1'b0;
    step();

    @(posedge clk);
    #2;
    chk("queue_drained", q_a.size() + q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
